// File: rtl/vid_pkg.sv
// Shared definitions for the video field arbiter: packet types, FSM states
// and the location of the interlace nibble inside the fourth control beat.
package vid_pkg;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    // Interlace nibble lives in data[19:16] of control beat index 3.
    localparam int INTERLACE_BIT = 19;
    localparam int FIELD_ID_BIT  = 18;

    // Beat index (0 = header) that carries the interlace nibble.
    localparam logic [2:0] PARITY_BEAT = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_GAP,
        ST_BODY
    } arb_state_e;

    // True when the SOP nibble marks a control packet.
    function automatic logic is_ctrl_type(input logic [3:0] pkt_type);
        return pkt_type == PKT_CTRL;
    endfunction

endpackage

// File: rtl/vid_field_arbiter_if.sv
// Avalon-ST video stream bundle (data, SOP/EOP, valid/ready).
// master drives the beat, slave drives ready.
interface vid_field_arbiter_if #(
    parameter int DATA_W = 24
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              startofpacket;
    logic              endofpacket;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );

endinterface

// File: rtl/avst_skid_buffer.sv
// Two-entry Avalon-ST skid buffer carrying data plus SOP/EOP.
// The output is taken straight from storage, and in_ready depends only on
// the fill level, so neither side sees a combinational path from the other.
module avst_skid_buffer #(
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int W = DATA_W + 2;

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign {out_sop, out_eop, out_data} = mem_q[rd_ptr_q];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next storage contents, pointers and fill level from push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_sop, in_eop, in_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the buffer and zeroes data.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vid_field_arbiter.sv
// Packet-atomic round-robin arbiter for two Avalon-ST video sources.
// A grant spans a control packet plus the following non-control packet, so
// frame parameters never get separated from their pixels. Also tracks field
// parity per source and counts completed frame units.
module vid_field_arbiter
    import vid_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    vid_field_arbiter_if.slave   asi_in0,
    vid_field_arbiter_if.slave   asi_in1,
    vid_field_arbiter_if.master  aso_out0,
    output logic                 grant,
    output logic [CNT_W-1:0]     unit_count,
    output logic                 parity_err
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  unit_count_q, unit_count_d;
    logic [2:0]        beat_idx_q, beat_idx_d;
    logic [1:0]        field_id_q, field_id_d;
    logic [1:0]        field_vld_q, field_vld_d;
    logic              parity_err_q, parity_err_d;

    logic [1:0]        in_valid, in_sop, in_eop, in_ready, req;
    logic [DATA_W-1:0] in_data [2];
    logic              pick, sel;
    logic              pkt_start, beat_acc, unit_done;
    logic [DATA_W-1:0] sel_data;

    logic [DATA_W-1:0] buf_in_data;
    logic              buf_in_sop, buf_in_eop, buf_in_valid, buf_in_ready;

    assign in_valid   = {asi_in1.valid, asi_in0.valid};
    assign in_sop     = {asi_in1.startofpacket, asi_in0.startofpacket};
    assign in_eop     = {asi_in1.endofpacket, asi_in0.endofpacket};
    assign in_data[0] = asi_in0.data;
    assign in_data[1] = asi_in1.data;
    assign asi_in0.ready = in_ready[0];
    assign asi_in1.ready = in_ready[1];

    assign grant      = grant_q;
    assign unit_count = unit_count_q;
    assign parity_err = parity_err_q;

    // Requester choice in IDLE: the input not granted last wins a tie.
    always_comb begin
        req  = in_valid & in_sop;
        pick = (req == 2'b11) ? ~last_q : req[1];
        sel  = (state_q == ST_IDLE) ? pick : grant_q;
        sel_data = in_data[sel];
    end

    // FSM next state, input readies, buffer push, parity and unit counting.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        unit_count_d = unit_count_q;
        beat_idx_d   = beat_idx_q;
        field_id_d   = field_id_q;
        field_vld_d  = field_vld_q;
        parity_err_d = 1'b0;
        in_ready     = 2'b00;
        buf_in_valid = 1'b0;
        buf_in_data  = sel_data;
        buf_in_sop   = in_sop[sel];
        buf_in_eop   = in_eop[sel];
        pkt_start    = 1'b0;
        beat_acc     = 1'b0;
        unit_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < 2; i++) begin
                    if (in_valid[i] && !in_sop[i]) begin
                        in_ready[i] = 1'b1;
                    end
                end
                if (req != 2'b00) begin
                    in_ready[pick] = buf_in_ready;
                    buf_in_valid   = 1'b1;
                    pkt_start      = buf_in_ready;
                end
            end
            ST_CTRL, ST_BODY: begin
                in_ready[grant_q] = buf_in_ready;
                buf_in_valid      = in_valid[grant_q];
                beat_acc          = in_valid[grant_q] & buf_in_ready;
            end
            ST_GAP: begin
                in_ready[grant_q] = buf_in_ready;
                buf_in_valid      = in_valid[grant_q] & in_sop[grant_q];
                pkt_start         = buf_in_valid & buf_in_ready;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_start) begin
            grant_d = sel;
            if (is_ctrl_type(sel_data[3:0])) begin
                beat_idx_d = 3'd1;
                state_d    = in_eop[sel] ? ST_GAP : ST_CTRL;
            end else begin
                state_d   = in_eop[sel] ? ST_IDLE : ST_BODY;
                unit_done = in_eop[sel];
            end
        end

        if (beat_acc) begin
            if (state_q == ST_CTRL) begin
                if (beat_idx_q == PARITY_BEAT) begin
                    if (sel_data[INTERLACE_BIT] && field_vld_q[grant_q] &&
                        (sel_data[FIELD_ID_BIT] == field_id_q[grant_q])) begin
                        parity_err_d = 1'b1;
                    end
                    field_id_d[grant_q]  = sel_data[FIELD_ID_BIT];
                    field_vld_d[grant_q] = 1'b1;
                end
                if (beat_idx_q < 3'd4) begin
                    beat_idx_d = beat_idx_q + 3'd1;
                end
                if (in_eop[grant_q]) begin
                    state_d = ST_GAP;
                end
            end else if (in_eop[grant_q]) begin
                state_d   = ST_IDLE;
                unit_done = 1'b1;
            end
        end

        if (unit_done) begin
            unit_count_d = unit_count_q + 1'b1;
            last_d       = sel;
        end

        if (reset) begin
            in_ready = 2'b00;
        end
    end

    // Arbiter state registers; reset favours input 0 on the first decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            unit_count_q <= '0;
            beat_idx_q   <= 3'd0;
            field_id_q   <= 2'b00;
            field_vld_q  <= 2'b00;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            unit_count_q <= unit_count_d;
            beat_idx_q   <= beat_idx_d;
            field_id_q   <= field_id_d;
            field_vld_q  <= field_vld_d;
            parity_err_q <= parity_err_d;
        end
    end

    avst_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_data   (buf_in_data),
        .in_sop    (buf_in_sop),
        .in_eop    (buf_in_eop),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .out_data  (aso_out0.data),
        .out_sop   (aso_out0.startofpacket),
        .out_eop   (aso_out0.endofpacket),
        .out_valid (aso_out0.valid),
        .out_ready (aso_out0.ready)
    );

endmodule

// File: tb/tb_vid_field_arbiter.sv
// Self-checking bench for vid_field_arbiter: a cycle table for the basic
// single-source unit, then queue-driven sequences for arbitration, parity,
// backpressure, stray beats and reset mid-unit.
module tb_vid_field_arbiter;
    import vid_pkg::*;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             grant;
    logic [CNT_W-1:0] unit_count;
    logic             parity_err;

    vid_field_arbiter_if #(.DATA_W(DATA_W)) in0_if ();
    vid_field_arbiter_if #(.DATA_W(DATA_W)) in1_if ();
    vid_field_arbiter_if #(.DATA_W(DATA_W)) out_if ();

    vid_field_arbiter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .asi_in0    (in0_if),
        .asi_in1    (in1_if),
        .aso_out0   (out_if),
        .grant      (grant),
        .unit_count (unit_count),
        .parity_err (parity_err)
    );

    // 100 MHz free-running clock.
    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    typedef struct {
        logic              in0_valid, in0_sop, in0_eop;
        logic [DATA_W-1:0] in0_data;
        logic              out_ready;
        logic              exp_rdy0, exp_rdy1;
        logic              exp_valid, exp_sop, exp_eop;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t q_in0 [$];
    beat_t q_in1 [$];
    beat_t q_exp [$];
    beat_t q_obs [$];
    int    pulse_count;
    logic [DATA_W-1:0] pulse_data;
    vec_t  vecs [9];

    // One comparison: counts it, reports a FAIL line on a difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one table row onto the inputs.
    task automatic applyStimulus(input vec_t v);
        in0_if.valid         = v.in0_valid;
        in0_if.startofpacket = v.in0_sop;
        in0_if.endofpacket   = v.in0_eop;
        in0_if.data          = v.in0_data;
        in1_if.valid         = 1'b0;
        in1_if.startofpacket = 1'b0;
        in1_if.endofpacket   = 1'b0;
        in1_if.data          = '0;
        out_if.ready         = v.out_ready;
    endtask

    // Park both sources idle with downstream ready.
    task automatic driveIdle();
        in0_if.valid = 1'b0; in0_if.startofpacket = 1'b0; in0_if.endofpacket = 1'b0; in0_if.data = '0;
        in1_if.valid = 1'b0; in1_if.startofpacket = 1'b0; in1_if.endofpacket = 1'b0; in1_if.data = '0;
        out_if.ready = 1'b1;
    endtask

    // Hold reset for three cycles and release it #1 after a rising edge.
    task automatic doReset();
        driveIdle();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        q_in0.delete(); q_in1.delete(); q_exp.delete(); q_obs.delete();
        pulse_count = 0;
        pulse_data  = '0;
    endtask

    // Queue a beat on a source, optionally also as an expected output beat.
    task automatic addBeat(input int port, input logic [DATA_W-1:0] d, input logic s,
                           input logic e, input bit expect_out);
        beat_t b;
        b = '{data: d, sop: s, eop: e};
        if (port == 0) q_in0.push_back(b);
        else           q_in1.push_back(b);
        if (expect_out) q_exp.push_back(b);
    endtask

    // Four-beat control packet whose last beat carries the interlace nibble.
    task automatic addCtrl(input int port, input logic [DATA_W-1:0] nibble_beat);
        addBeat(port, 24'h00000F, 1'b1, 1'b0, 1'b1);
        addBeat(port, 24'h000280, 1'b0, 1'b0, 1'b1);
        addBeat(port, 24'h0000F0, 1'b0, 1'b0, 1'b1);
        addBeat(port, nibble_beat, 1'b0, 1'b1, 1'b1);
    endtask

    // Three-beat video packet tagged so beats from different units differ.
    task automatic addVideo(input int port, input logic [DATA_W-1:0] tag);
        addBeat(port, {20'h00000, PKT_VIDEO}, 1'b1, 1'b0, 1'b1);
        addBeat(port, tag + 24'd1, 1'b0, 1'b0, 1'b1);
        addBeat(port, tag + 24'd2, 1'b0, 1'b1, 1'b1);
    endtask

    // Stream the source queues into the DUT and capture accepted output beats,
    // checking that a stalled output beat stays put until it is taken.
    task automatic runTraffic(input int max_cycles, input bit rand_ready);
        int    cyc;
        bit    done;
        bit    hold_pending;
        beat_t held;
        beat_t b;
        cyc = 0; done = 0; hold_pending = 0; held = '0;
        while (!done) begin
            if (q_in0.size() > 0) begin
                b = q_in0[0];
                in0_if.valid = 1'b1; in0_if.data = b.data;
                in0_if.startofpacket = b.sop; in0_if.endofpacket = b.eop;
            end else begin
                in0_if.valid = 1'b0; in0_if.startofpacket = 1'b0; in0_if.endofpacket = 1'b0;
            end
            if (q_in1.size() > 0) begin
                b = q_in1[0];
                in1_if.valid = 1'b1; in1_if.data = b.data;
                in1_if.startofpacket = b.sop; in1_if.endofpacket = b.eop;
            end else begin
                in1_if.valid = 1'b0; in1_if.startofpacket = 1'b0; in1_if.endofpacket = 1'b0;
            end
            out_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            if (in0_if.valid && in0_if.ready) void'(q_in0.pop_front());
            if (in1_if.valid && in1_if.ready) void'(q_in1.pop_front());
            if (parity_err) begin
                pulse_count++;
                pulse_data = out_if.data;
            end
            if (hold_pending) begin
                checkOutput("hold_valid", {31'd0, out_if.valid}, 32'd1);
                checkOutput("hold_beat",
                            {6'd0, out_if.data, out_if.startofpacket, out_if.endofpacket},
                            {6'd0, held});
            end
            hold_pending = out_if.valid && !out_if.ready;
            held = '{data: out_if.data, sop: out_if.startofpacket, eop: out_if.endofpacket};
            if (out_if.valid && out_if.ready) q_obs.push_back(held);
            @(posedge clock);
            #1;
            cyc++;
            if (q_in0.size() == 0 && q_in1.size() == 0 && !out_if.valid) done = 1;
            if (!done && cyc >= max_cycles) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL traffic_timeout: %0d cycles elapsed, required drain within %0d", cyc, max_cycles);
                done = 1;
            end
        end
        driveIdle();
    endtask

    // Compare captured output beats against the expected stream, then clear.
    task automatic compareStreams(input string name);
        int n;
        checkOutput({name, "_beats"}, q_obs.size(), q_exp.size());
        n = (q_obs.size() < q_exp.size()) ? q_obs.size() : q_exp.size();
        for (int i = 0; i < n; i++) begin
            if (q_obs[i] !== q_exp[i]) begin
                checkOutput($sformatf("%s_beat%0d", name, i), {6'd0, q_obs[i]}, {6'd0, q_exp[i]});
            end else begin
                compared++;
            end
        end
        q_obs.delete();
        q_exp.delete();
    endtask

    // Overall time guard so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        // Cycle table: ctrl 0x00000F + 3 beats, then a 3-beat video packet on in0.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 24'h00000F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 24'h000280, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00000F};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 24'h0000F0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000280};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0000F0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 24'h112233, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 24'h445566, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h112233};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h445566};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

        doReset();
        $display("[TB] reset state");
        @(negedge clock);
        checkOutput("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        checkOutput("rst_out_sop", {31'd0, out_if.startofpacket}, 32'd0);
        checkOutput("rst_out_eop", {31'd0, out_if.endofpacket}, 32'd0);
        checkOutput("rst_out_data", {8'd0, out_if.data}, 32'd0);
        checkOutput("rst_rdy0", {31'd0, in0_if.ready}, 32'd0);
        checkOutput("rst_rdy1", {31'd0, in1_if.ready}, 32'd0);
        checkOutput("rst_grant", {31'd0, grant}, 32'd0);
        checkOutput("rst_unit_count", {16'd0, unit_count}, 32'd0);
        checkOutput("rst_parity_err", {31'd0, parity_err}, 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] single-source table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput($sformatf("tbl%0d_rdy0", i), {31'd0, in0_if.ready}, {31'd0, vecs[i].exp_rdy0});
            checkOutput($sformatf("tbl%0d_rdy1", i), {31'd0, in1_if.ready}, {31'd0, vecs[i].exp_rdy1});
            checkOutput($sformatf("tbl%0d_valid", i), {31'd0, out_if.valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("tbl%0d_data", i), {8'd0, out_if.data}, {8'd0, vecs[i].exp_data});
                checkOutput($sformatf("tbl%0d_sop", i), {31'd0, out_if.startofpacket}, {31'd0, vecs[i].exp_sop});
                checkOutput($sformatf("tbl%0d_eop", i), {31'd0, out_if.endofpacket}, {31'd0, vecs[i].exp_eop});
            end
            @(posedge clock);
            #1;
        end
        checkOutput("tbl_unit_count", {16'd0, unit_count}, 32'd1);
        checkOutput("tbl_grant", {31'd0, grant}, 32'd0);
        driveIdle();

        $display("[TB] simultaneous SOP on both inputs");
        doReset();
        addCtrl(0, 24'h000000); addVideo(0, 24'h100000);
        addCtrl(1, 24'h000000); addVideo(1, 24'h200000);
        runTraffic(200, 1'b0);
        compareStreams("both_sop");
        checkOutput("both_unit_count", {16'd0, unit_count}, 32'd2);
        checkOutput("both_grant", {31'd0, grant}, 32'd1);

        $display("[TB] field parity 0,1,1 on in0");
        doReset();
        addCtrl(0, 24'h080001); addVideo(0, 24'h300000);
        addCtrl(0, 24'h0C0002); addVideo(0, 24'h310000);
        addCtrl(0, 24'h0C0003); addVideo(0, 24'h320000);
        runTraffic(200, 1'b0);
        compareStreams("parity");
        checkOutput("parity_pulses", pulse_count, 32'd1);
        checkOutput("parity_pulse_beat", {8'd0, pulse_data}, 32'h0C0003);
        checkOutput("parity_unit_count", {16'd0, unit_count}, 32'd3);

        $display("[TB] random downstream ready");
        doReset();
        addCtrl(0, 24'h000000); addVideo(0, 24'h400000);
        addCtrl(1, 24'h000000); addVideo(1, 24'h500000);
        runTraffic(1000, 1'b1);
        compareStreams("bp");
        checkOutput("bp_unit_count", {16'd0, unit_count}, 32'd2);

        $display("[TB] stray non-SOP beat on in1");
        doReset();
        addBeat(1, 24'h123456, 1'b0, 1'b0, 1'b0);
        addCtrl(1, 24'h000000); addVideo(1, 24'h600000);
        runTraffic(200, 1'b0);
        compareStreams("stray");
        checkOutput("stray_unit_count", {16'd0, unit_count}, 32'd1);
        checkOutput("stray_grant", {31'd0, grant}, 32'd1);

        $display("[TB] reset mid-BODY");
        doReset();
        addCtrl(0, 24'h000000); addVideo(0, 24'h700000);
        addCtrl(0, 24'h000000);
        addBeat(0, {20'h00000, PKT_VIDEO}, 1'b1, 1'b0, 1'b1);
        addBeat(0, 24'h710001, 1'b0, 1'b0, 1'b1);
        runTraffic(200, 1'b0);
        compareStreams("pre_rst");
        checkOutput("pre_rst_unit_count", {16'd0, unit_count}, 32'd1);
        in0_if.valid = 1'b1; in0_if.data = 24'h777777;
        in0_if.startofpacket = 1'b0; in0_if.endofpacket = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("in_rst_rdy0", {31'd0, in0_if.ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        driveIdle();
        @(negedge clock);
        checkOutput("post_rst_valid", {31'd0, out_if.valid}, 32'd0);
        checkOutput("post_rst_unit_count", {16'd0, unit_count}, 32'd0);
        checkOutput("post_rst_grant", {31'd0, grant}, 32'd0);
        @(posedge clock);
        #1;
        addCtrl(1, 24'h000000);
        runTraffic(100, 1'b0);
        compareStreams("post_rst");
        checkOutput("post_rst_grant1", {31'd0, grant}, 32'd1);
        checkOutput("post_rst_count_hold", {16'd0, unit_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
